// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings OP_AND..OP_XOR (1100-1111 fall back to ADD)
//   - FSM state encoding for mc_alu
//   - is_multicycle(): ops that run on the iterative mul/div engine
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring
// unsigned divider sharing one set of registers.
//   clk, reset    : clock, synchronous active-high reset
//   go            : load operands and start DATA_WIDTH iterations
//   is_div        : 1 = divide a/b, 0 = multiply a*b (low half)
//   a, b          : operands, captured on go
//   last          : the step taken at the coming edge is the final one
//   quot_or_prod  : quotient/product as it will be after that step
//   rem           : remainder as it will be after that step
// Outputs are the post-step values so the owner can register the final
// answer on the same edge that performs the last iteration.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] quot_or_prod,
    output logic [DATA_WIDTH-1:0] rem
);
    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    // acc : product (mul) / partial remainder (div)
    // opa : multiplicand shifting left (mul) / divisor (div)
    // opb : multiplier shifting right (mul) / dividend->quotient (div)
    logic [DW-1:0]    acc, opa, opb;
    logic [CNT_W-1:0] cnt;
    logic             run, div_r;

    logic [DW:0]   r_sh, diff;
    logic          qbit;
    logic [DW-1:0] r_nxt, q_nxt, p_nxt;

    always_comb begin
        // Remainder gets one extra bit so 2*rem+1 never overflows.
        r_sh  = {acc, opb[DW-1]};
        diff  = r_sh - {1'b0, opa};
        qbit  = ~diff[DW];
        r_nxt = qbit ? diff[DW-1:0] : r_sh[DW-1:0];
        q_nxt = {opb[DW-2:0], qbit};
        p_nxt = opb[0] ? (acc + opa) : acc;
    end

    assign last         = run && (cnt == CNT_W'(DW - 1));
    assign quot_or_prod = div_r ? q_nxt : p_nxt;
    assign rem          = r_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            div_r <= 1'b0;
        end else if (go) begin
            acc   <= '0;
            opa   <= is_div ? b : a;
            opb   <= is_div ? a : b;
            cnt   <= '0;
            run   <= 1'b1;
            div_r <= is_div;
        end else if (run) begin
            if (div_r) begin
                acc <= r_nxt;
                opb <= q_nxt;
            end else begin
                acc <= p_nxt;
                opa <= opa << 1;
                opb <= opb >> 1;
            end
            cnt <= cnt + 1'b1;
            if (last) run <= 1'b0;
        end
    end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with start/done handshake.
//   clk, reset        : clock, synchronous active-high reset
//   start             : request, taken only while ready=1
//   opcode            : operation select (see alu_pkg)
//   input1, input2    : operands A and B
//   ready             : can accept start
//   done              : one-cycle pulse, result/flags valid
//   result            : registered result, held until next done
//   z/n/v/dz_flag     : zero, negative, signed overflow, divide-by-zero
// Single-cycle ops (and divide by zero) finish on the accepting edge;
// MUL/DIVU/REMU go through BUSY for DATA_WIDTH iterations, then DONE.
module mc_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] input1,
    input  logic [DATA_WIDTH-1:0] input2,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z_flag,
    output logic                  n_flag,
    output logic                  v_flag,
    output logic                  dz_flag
);
    localparam int MSB = DATA_WIDTH - 1;

    state_t state, state_nxt;
    logic [3:0] op_r;

    logic                  accept, is_div_op, div_zero, mc_go;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] sc_res;
    logic                  sc_v;

    logic                  eng_last;
    logic [DATA_WIDTH-1:0] eng_qp, eng_rem;

    // DONE also accepts a new request: the engine answer was already
    // registered when BUSY left, so nothing is pending there.
    assign ready     = (state != BUSY);
    assign accept    = start && ready;
    assign is_div_op = (opcode == OP_DIVU) || (opcode == OP_REMU);
    assign div_zero  = is_div_op && (input2 == '0);
    assign mc_go     = accept && is_multicycle(opcode) && !div_zero;
    assign shamt     = input2[SHAMT_W-1:0];

    always_comb begin
        sc_res = input1 + input2;
        sc_v   = 1'b0;
        case (opcode)
            OP_AND:  sc_res = input1 & input2;
            OP_OR:   sc_res = input1 | input2;
            OP_XOR:  sc_res = input1 ^ input2;
            OP_SUB: begin
                sc_res = input1 - input2;
                sc_v   = (input1[MSB] != input2[MSB]) && (sc_res[MSB] != input1[MSB]);
            end
            OP_SLL:  sc_res = input1 << shamt;
            OP_SRL:  sc_res = input1 >> shamt;
            OP_SRA:  sc_res = $signed(input1) >>> shamt;
            OP_SLT:  sc_res = DATA_WIDTH'($signed(input1) < $signed(input2));
            OP_DIVU: sc_res = '1;      // only reached with input2 == 0
            OP_REMU: sc_res = input1;  // only reached with input2 == 0
            OP_MUL:  sc_res = '0;      // never takes the single-cycle path
            default: begin             // ADD and 1100-1111
                sc_res = input1 + input2;
                sc_v   = (input1[MSB] == input2[MSB]) && (sc_res[MSB] != input1[MSB]);
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BUSY:    if (eng_last) state_nxt = DONE;
            default: state_nxt = mc_go ? BUSY : IDLE;
        endcase
    end

    alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk          (clk),
        .reset        (reset),
        .go           (mc_go),
        .is_div       (is_div_op),
        .a            (input1),
        .b            (input2),
        .last         (eng_last),
        .quot_or_prod (eng_qp),
        .rem          (eng_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= OP_AND;
            done    <= 1'b0;
            result  <= '0;
            z_flag  <= 1'b1;
            n_flag  <= 1'b0;
            v_flag  <= 1'b0;
            dz_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (mc_go) begin
                op_r <= opcode;
            end else if (accept) begin
                done    <= 1'b1;
                result  <= sc_res;
                z_flag  <= (sc_res == '0);
                n_flag  <= sc_res[MSB];
                v_flag  <= sc_v;
                dz_flag <= div_zero;
            end
            if (state == BUSY && eng_last) begin
                done    <= 1'b1;
                result  <= (op_r == OP_REMU) ? eng_rem : eng_qp;
                z_flag  <= (((op_r == OP_REMU) ? eng_rem : eng_qp) == '0);
                n_flag  <= (op_r == OP_REMU) ? eng_rem[MSB] : eng_qp[MSB];
                v_flag  <= 1'b0;
                dz_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  opcode;
    logic [31:0] input1, input2;
    logic        ready, done, z_flag, n_flag, v_flag, dz_flag;
    logic [31:0] result;

    logic        start8;
    logic [3:0]  opcode8;
    logic [7:0]  in1_8, in2_8, result8;
    logic        ready8, done8, z8, n8, v8, dz8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_alu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .input1(input1), .input2(input2), .ready(ready), .done(done),
        .result(result), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag),
        .dz_flag(dz_flag)
    );

    mc_alu #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .opcode(opcode8),
        .input1(in1_8), .input2(in2_8), .ready(ready8), .done(done8),
        .result(result8), .z_flag(z8), .n_flag(n8), .v_flag(v8),
        .dz_flag(dz8)
    );

    // Issue one request and wait for done (bounded). lat = cycles from the
    // sampling edge to the done cycle; rdy_low = cycles seen with ready=0.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int rdy_low);
        @(posedge clk); #1;
        start = 1'b1; opcode = op; input1 = a; input2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; rdy_low = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (ready === 1'b0) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; opcode = OP_AND; input1 = '0; input2 = '0;
        start8 = 1'b0; opcode8 = OP_AND; in1_8 = '0; in2_8 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({ready, done, result, z_flag, n_flag, v_flag, dz_flag} !== {1'b1, 1'b0, 32'h0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset: got rdy=%b done=%b res=%h z=%b n=%b v=%b dz=%b expected 1 0 00000000 1 0 0 0",
                     ready, done, result, z_flag, n_flag, v_flag, dz_flag);
        end
    endtask

    task automatic test_add_sub;
        int lat, rl;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'h8000_0000 || {v_flag, n_flag, z_flag} !== 3'b110 || ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: got lat=%0d res=%h vnz=%b%b%b rdy=%b expected lat=1 res=80000000 vnz=110 rdy=1",
                     lat, result, v_flag, n_flag, z_flag, ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL add_hold: got done=%b res=%h expected done=0 res=80000000", done, result);
        end
        run_op(OP_SUB, 32'd5, 32'd5, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'h0 || {v_flag, n_flag, z_flag} !== 3'b001) begin
            errors++;
            $display("FAIL sub_zero: got lat=%0d res=%h vnz=%b%b%b expected lat=1 res=0 vnz=001",
                     lat, result, v_flag, n_flag, z_flag);
        end
        run_op(OP_SUB, 32'h8000_0000, 32'h1, lat, rl);
        checks++;
        if (result !== 32'h7FFF_FFFF || {v_flag, n_flag, z_flag} !== 3'b100) begin
            errors++;
            $display("FAIL sub_ovf: got res=%h vnz=%b%b%b expected res=7fffffff vnz=100",
                     result, v_flag, n_flag, z_flag);
        end
        run_op(4'b1110, 32'd40, 32'd2, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'd42) begin
            errors++;
            $display("FAIL op1110_add: got lat=%0d res=%h expected lat=1 res=0000002a", lat, result);
        end
    endtask

    task automatic test_mul;
        int lat, rl, extra;
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_MUL; input1 = 32'hFFFF_FFFD; input2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; rl = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (ready === 1'b0) rl++;
            // Disturb the request mid-operation: ignored start, new operands.
            if (lat == 5) begin start = 1'b1; opcode = OP_ADD; input1 = 32'h1234; input2 = 32'h1; end
            if (lat == 6) begin start = 1'b0; input2 = 32'h55; end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 33 || rl !== 32 || result !== 32'hFFFF_FFEB || ready !== 1'b1 || n_flag !== 1'b1) begin
            errors++;
            $display("FAIL mul: got lat=%0d rdy_low=%0d res=%h rdy=%b n=%b expected lat=33 rdy_low=32 res=ffffffeb rdy=1 n=1",
                     lat, rl, result, ready, n_flag);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_no_extra: got extra_done=%0d res=%h expected 0 ffffffeb", extra, result);
        end
    endtask

    task automatic test_div;
        int lat, rl;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, rl);
        checks++;
        if (lat !== 33 || result !== 32'd14 || dz_flag !== 1'b0) begin
            errors++;
            $display("FAIL divu: got lat=%0d res=%h dz=%b expected lat=33 res=0000000e dz=0", lat, result, dz_flag);
        end
        run_op(OP_REMU, 32'd100, 32'd7, lat, rl);
        checks++;
        if (lat !== 33 || result !== 32'd2) begin
            errors++;
            $display("FAIL remu: got lat=%0d res=%h expected lat=33 res=00000002", lat, result);
        end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h1_0000, lat, rl);
        checks++;
        if (result !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL divu_big: got res=%h expected 0000ffff", result);
        end
        run_op(OP_DIVU, 32'd9, 32'd0, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'hFFFF_FFFF || dz_flag !== 1'b1) begin
            errors++;
            $display("FAIL divu_zero: got lat=%0d res=%h dz=%b expected lat=1 res=ffffffff dz=1", lat, result, dz_flag);
        end
        run_op(OP_ADD, 32'd1, 32'd2, lat, rl);
        checks++;
        if (result !== 32'd3 || dz_flag !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got res=%h dz=%b expected res=00000003 dz=0", result, dz_flag);
        end
        run_op(OP_REMU, 32'd9, 32'd0, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'd9 || dz_flag !== 1'b1) begin
            errors++;
            $display("FAIL remu_zero: got lat=%0d res=%h dz=%b expected lat=1 res=00000009 dz=1", lat, result, dz_flag);
        end
    endtask

    task automatic test_shift_slt;
        int lat, rl;
        run_op(OP_SRA, 32'h8000_0000, 32'h21, lat, rl);
        checks++;
        if (result !== 32'hC000_0000) begin
            errors++;
            $display("FAIL sra: got res=%h expected c0000000", result);
        end
        run_op(OP_SRL, 32'h8000_0000, 32'h21, lat, rl);
        checks++;
        if (result !== 32'h4000_0000) begin
            errors++;
            $display("FAIL srl: got res=%h expected 40000000", result);
        end
        run_op(OP_SLL, 32'h0000_0003, 32'h24, lat, rl);
        checks++;
        if (result !== 32'h0000_0030) begin
            errors++;
            $display("FAIL sll: got res=%h expected 00000030", result);
        end
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, rl);
        checks++;
        if (result !== 32'd1 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL slt_true: got res=%h z=%b expected 00000001 z=0", result, z_flag);
        end
        run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, lat, rl);
        checks++;
        if (result !== 32'd0 || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL slt_false: got res=%h z=%b expected 00000000 z=1", result, z_flag);
        end
    endtask

    task automatic test_reset_mid_busy;
        int lat, rl, seen;
        run_op(OP_ADD, 32'd10, 32'd20, lat, rl);
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_MUL; input1 = 32'd3; input2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1 || result !== 32'h0 || z_flag !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got rdy=%b res=%h z=%b done=%b expected 1 00000000 1 0",
                     ready, result, z_flag, done);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_busy_nodone: got done_pulses=%0d expected 0", seen);
        end
        run_op(OP_ADD, 32'd6, 32'd7, lat, rl);
        checks++;
        if (lat !== 1 || result !== 32'd13) begin
            errors++;
            $display("FAIL add_after_reset: got lat=%0d res=%h expected lat=1 res=0000000d", lat, result);
        end
        // Reset and start together: reset wins, request dropped.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; opcode = OP_ADD; input1 = 32'd1; input2 = 32'd1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_and_start: got done=%b res=%h rdy=%b expected 0 00000000 1", done, result, ready);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_AND; input1 = 32'hF0F0_1234; input2 = 32'h0FF0_FF00;
        @(posedge clk); #1;
        opcode = OP_OR;
        checks++;
        if (done !== 1'b1 || result !== 32'h00F0_1200) begin
            errors++;
            $display("FAIL b2b_and: got done=%b res=%h expected 1 00f01200", done, result);
        end
        @(posedge clk); #1;
        opcode = OP_XOR;
        checks++;
        if (done !== 1'b1 || result !== 32'hFFF0_FF34) begin
            errors++;
            $display("FAIL b2b_or: got done=%b res=%h expected 1 fff0ff34", done, result);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'hFF00_ED34) begin
            errors++;
            $display("FAIL b2b_xor: got done=%b res=%h expected 1 ff00ed34", done, result);
        end
    endtask

    task automatic test_mul8;
        int lat;
        @(posedge clk); #1;
        start8 = 1'b1; opcode8 = OP_MUL; in1_8 = 8'h0F; in2_8 = 8'h11;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9 || result8 !== 8'hFF || n8 !== 1'b1) begin
            errors++;
            $display("FAIL mul8: got lat=%0d res=%h n=%b expected lat=9 res=ff n=1", lat, result8, n8);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift_slt();
        test_reset_mid_busy();
        test_back_to_back();
        test_mul8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
